seq_run_detector: RTL

Parametrised run-length sequence detector for the serial-input FSM blocks. Watches a qualified single-bit stream and flags runs of `RUN_LEN` identical bits, with selectable polarity (ones, zeros, both) and an overlap or restart mode. It also reports the current run length and keeps a saturating count of detections. It replaces the fixed 4-bit ones/zeros detector with a width- and mode-generic version that the same top levels can use.

---
 rtl/seq_run_detector.sv | 86 ++++++++
 1 files changed

// File: rtl/seq_run_detector.sv
// Run-length sequence detector: flags RUN_LEN identical accepted bits with
// selectable polarity and overlap/restart behaviour, plus a saturating hit counter.
module seq_run_detector #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in,
    input  logic [1:0]       mode,
    input  logic             clr_cnt,
    output logic             out,
    output logic             out_bit,
    output logic             hit,
    output logic [3:0]       run_len,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [3:0]       RUN_MAX = 4'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic [3:0]       run_reg, run_next;
    logic             last_reg, last_next;
    logic             out_reg, out_next;
    logic             hit_reg, hit_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    function automatic logic pol_ok(input logic b, input logic [1:0] m);
        case (m)
            2'b00:   pol_ok = b;
            2'b01:   pol_ok = ~b;
            default: pol_ok = 1'b1;
        endcase
    endfunction

    always_comb begin
        run_next  = run_reg;
        last_next = last_reg;
        hit_next  = 1'b0;
        if (in_valid) begin
            if (run_reg == 4'd0 || in != last_reg) begin
                run_next  = 4'd1;
                last_next = in;
            end else if (run_reg < RUN_MAX) begin
                run_next = run_reg + 4'd1;
            end else if (mode == 2'b11) begin
                run_next = 4'd1;
            end
            // Staying saturated at RUN_LEN is not a new detection.
            hit_next = (run_next == RUN_MAX) && (run_reg != RUN_MAX) && pol_ok(last_next, mode);
        end
        out_next = (run_next == RUN_MAX) && pol_ok(last_next, mode);

        cnt_next = cnt_reg;
        if (clr_cnt) begin
            cnt_next = hit_next ? CNT_ONE : '0;
        end else if (hit_next && cnt_reg != CNT_SAT) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_reg  <= 4'd0;
            last_reg <= 1'b0;
            out_reg  <= 1'b0;
            hit_reg  <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            run_reg  <= run_next;
            last_reg <= last_next;
            out_reg  <= out_next;
            hit_reg  <= hit_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign out       = out_reg;
    assign out_bit   = last_reg;
    assign hit       = hit_reg;
    assign run_len   = run_reg;
    assign match_cnt = cnt_reg;

endmodule
